// File: rtl/calc1.sv
// rtl/calc1.sv - four independent add/subtract/shift calculator ports.
// Optional shift commands (5, 6) are compiled in only when CALC1_SHIFT_EN is defined.

module calc1_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [1:0]  resp_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, OPND2 = 2'd1, RESP = 2'd2} state_e;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  resp_q, resp_d;
  logic [32:0] sum;
  logic [31:0] diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= 4'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      data_q  <= 32'd0;
      resp_q  <= RESP_NONE;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      IDLE: begin
        if (cmd_i != 4'd0) begin
          cmd_d   = cmd_i;
          op1_d   = data_i;
          state_d = OPND2;
        end
      end
      OPND2: begin
        op2_d   = data_i;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum  = {1'b0, op1_q} + {1'b0, op2_q};
  assign diff = op1_q - op2_q;

  // Result is registered on leaving RESP, so it is visible for the cycle after it.
  always_comb begin
    data_d = 32'd0;
    resp_d = RESP_NONE;
    if (state_q == RESP) begin
      resp_d = RESP_ERR;
      case (cmd_q)
        4'd1: begin
          if (!sum[32]) begin
            resp_d = RESP_OK;
            data_d = sum[31:0];
          end
        end
        4'd2: begin
          if (op2_q <= op1_q) begin
            resp_d = RESP_OK;
            data_d = diff;
          end
        end
`ifdef CALC1_SHIFT_EN
        4'd5: begin
          resp_d = RESP_OK;
          data_d = op1_q << op2_q[4:0];
        end
        4'd6: begin
          resp_d = RESP_OK;
          data_d = op1_q >> op2_q[4:0];
        end
`endif
        default: ;
      endcase
    end
  end

  assign data_o = data_q;
  assign resp_o = resp_q;
endmodule

module calc1 (
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4,
  input  logic        c_clk,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  input  logic [1:7]  reset
);
  logic rst;

  assign rst = |reset;

  calc1_port u_port1 (.clk(c_clk), .rst(rst), .cmd_i(req1_cmd_in), .data_i(req1_data_in),
                      .data_o(out_data1), .resp_o(out_resp1));
  calc1_port u_port2 (.clk(c_clk), .rst(rst), .cmd_i(req2_cmd_in), .data_i(req2_data_in),
                      .data_o(out_data2), .resp_o(out_resp2));
  calc1_port u_port3 (.clk(c_clk), .rst(rst), .cmd_i(req3_cmd_in), .data_i(req3_data_in),
                      .data_o(out_data3), .resp_o(out_resp3));
  calc1_port u_port4 (.clk(c_clk), .rst(rst), .cmd_i(req4_cmd_in), .data_i(req4_data_in),
                      .data_o(out_data4), .resp_o(out_resp4));
endmodule

// File: tb/tb_calc1.sv
// tb/tb_calc1.sv - table-driven and scoreboard bench for calc1.
// Shift expectations follow CALC1_SHIFT_EN.

module tb_calc1;
  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [0:3]  cmd [1:4];
  logic [0:31] din [1:4];
  logic [0:31] out_data [1:4];
  logic [0:1]  out_resp [1:4];

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  exp_t        sbq [4][$];
  vec_t        vecs [$];
  logic [31:0] pend_b [1:4];
  bit          act [1:4];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  calc1 dut (
    .out_data1(out_data[1]), .out_data2(out_data[2]), .out_data3(out_data[3]), .out_data4(out_data[4]),
    .out_resp1(out_resp[1]), .out_resp2(out_resp[2]), .out_resp3(out_resp[3]), .out_resp4(out_resp[4]),
    .c_clk(c_clk),
    .req1_cmd_in(cmd[1]), .req1_data_in(din[1]),
    .req2_cmd_in(cmd[2]), .req2_data_in(din[2]),
    .req3_cmd_in(cmd[3]), .req3_data_in(din[3]),
    .req4_cmd_in(cmd[4]), .req4_data_in(din[4]),
    .reset(reset)
  );

  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc++;

  task automatic chk(input string nm, input int p, input logic [1:0] gr, input logic [31:0] gd,
                     input logic [1:0] er, input logic [31:0] ed);
    total++;
    if (gr !== er || gd !== ed) begin
      bad++;
      $display("FAIL %s port%0d cyc=%0d got resp=%0d data=%h want resp=%0d data=%h",
               nm, p, cyc, gr, gd, er, ed);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
    logic [63:0] w;
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        w = {32'd0, a} + {32'd0, b};
        if (w <= 64'h0000_0000_FFFF_FFFF) begin r = 2'd1; d = w[31:0]; end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
`ifdef CALC1_SHIFT_EN
      4'd5: begin w = {32'd0, a} * (64'd1 << b[4:0]); r = 2'd1; d = w[31:0]; end
      4'd6: begin r = 2'd1; d = a / (32'd1 << b[4:0]); end
`endif
      default: ;
    endcase
  endfunction

  // Every port is checked on every falling edge: either the due result or all zeros.
  always @(negedge c_clk) begin
    for (int p = 1; p <= 4; p++) begin
      while (sbq[p-1].size() > 0 && sbq[p-1][0].cyc < cyc) begin
        chk("missed", p, out_resp[p], out_data[p], sbq[p-1][0].resp, sbq[p-1][0].data);
        void'(sbq[p-1].pop_front());
      end
      if (sbq[p-1].size() > 0 && sbq[p-1][0].cyc == cyc) begin
        chk("result", p, out_resp[p], out_data[p], sbq[p-1][0].resp, sbq[p-1][0].data);
        void'(sbq[p-1].pop_front());
      end else begin
        chk("idle", p, out_resp[p], out_data[p], 2'd0, 32'd0);
      end
    end
  end

  task automatic launch(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_out, input logic [1:0] r, input logic [31:0] d);
    exp_t e;
    cmd[p]    = c;
    din[p]    = a;
    pend_b[p] = b;
    act[p]    = 1'b1;
    if (expect_out) begin
      e.cyc  = cyc + 3;
      e.resp = r;
      e.data = d;
      sbq[p-1].push_back(e);
    end
  endtask

  task automatic step3();
    @(posedge c_clk); #1;
    for (int p = 1; p <= 4; p++)
      if (act[p]) begin cmd[p] = 4'd0; din[p] = pend_b[p]; end
    @(posedge c_clk); #1;
    for (int p = 1; p <= 4; p++) begin din[p] = 32'd0; act[p] = 1'b0; end
    @(posedge c_clk); #1;
  endtask

  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] r, input logic [31:0] d);
    launch(p, c, a, b, 1'b1, r, d);
    step3();
  endtask

  task automatic issue_m(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  r;
    logic [31:0] d;
    model(c, a, b, r, d);
    issue(p, c, a, b, r, d);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d, x, a, b;
    logic [3:0]  c;

    reset = 7'b1111111;
    for (int p = 1; p <= 4; p++) begin cmd[p] = 4'd0; din[p] = 32'd0; act[p] = 1'b0; pend_b[p] = 32'd0; end

    vecs.push_back('{4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000});
    vecs.push_back('{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000});
    vecs.push_back('{4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE});
    vecs.push_back('{4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000});
    vecs.push_back('{4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E});
    vecs.push_back('{4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0000_0000});
    vecs.push_back('{4'd3, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000});
    vecs.push_back('{4'd4, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000});
    vecs.push_back('{4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000});
    vecs.push_back('{4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF});
    vecs.push_back('{4'd7, 32'h0000_0005, 32'h0000_0003, 2'd2, 32'h0000_0000});
    vecs.push_back('{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000});
`ifdef CALC1_SHIFT_EN
    vecs.push_back('{4'd5, 32'h0000_00F0, 32'h0000_0000, 2'd1, 32'h0000_00F0});
    vecs.push_back('{4'd6, 32'h0000_00F0, 32'hFFFF_FFE0, 2'd1, 32'h0000_00F0});
    vecs.push_back('{4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 32'h0000_0001});
    vecs.push_back('{4'd5, 32'h8000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002});
`else
    vecs.push_back('{4'd5, 32'h0000_00F0, 32'h0000_0001, 2'd2, 32'h0000_0000});
    vecs.push_back('{4'd6, 32'h0000_00F0, 32'h0000_0001, 2'd2, 32'h0000_0000});
`endif

    #1;
    for (int p = 1; p <= 4; p++) chk("reset_state", p, out_resp[p], out_data[p], 2'd0, 32'd0);
    repeat (2) @(posedge c_clk);
    #1;
    reset = 7'b0000000;

    for (int i = 0; i < vecs.size(); i++)
      issue(1, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].resp, vecs[i].data);

    for (int i = 0; i <= 30; i++) begin
      x = 32'd1 << i;
      issue((i % 4) + 1, 4'd1, x, 32'd0, 2'd1, x);
      if (i <= 29) begin
`ifdef CALC1_SHIFT_EN
        issue((i % 4) + 1, 4'd5, x, 32'd1, 2'd1, x + x);
`else
        issue((i % 4) + 1, 4'd5, x, 32'd1, 2'd2, 32'd0);
`endif
      end
    end

    launch(1, 4'd1, 32'h0000_0010, 32'h0000_0001, 1'b1, 2'd1, 32'h0000_0011);
    launch(2, 4'd1, 32'h0000_0200, 32'h0000_0002, 1'b1, 2'd1, 32'h0000_0202);
    launch(3, 4'd1, 32'h0000_3000, 32'h0000_0003, 1'b1, 2'd1, 32'h0000_3003);
    launch(4, 4'd1, 32'hFFFF_FFFF, 32'h0000_0004, 1'b1, 2'd2, 32'h0000_0000);
    step3();

    // Abort in OPND2 with reset[1]; the port must accept the very next command.
    launch(1, 4'd1, 32'd5, 32'd6, 1'b0, 2'd0, 32'd0);
    @(posedge c_clk); #1;
    cmd[1] = 4'd0; din[1] = 32'd6;
    #1 reset = 7'b1000000;
    #1 reset = 7'b0000000;
    @(posedge c_clk); #1;
    din[1] = 32'd0; act[1] = 1'b0;
    issue(1, 4'd1, 32'd7, 32'd8, 2'd1, 32'd15);

    launch(2, 4'd2, 32'd9, 32'd4, 1'b0, 2'd0, 32'd0);
    @(posedge c_clk); #1;
    cmd[2] = 4'd0; din[2] = 32'd4;
    @(posedge c_clk); #1;
    din[2] = 32'd0;
    #1 reset = 7'b0000001;
    #1 reset = 7'b0000000;
    @(posedge c_clk); #1;
    act[2] = 1'b0;
    issue(2, 4'd2, 32'd9, 32'd4, 2'd1, 32'd5);

    // A command presented during RESP must be ignored.
    launch(3, 4'd1, 32'd2, 32'd3, 1'b1, 2'd1, 32'd5);
    @(posedge c_clk); #1;
    cmd[3] = 4'd0; din[3] = 32'd3;
    @(posedge c_clk); #1;
    cmd[3] = 4'd1; din[3] = 32'd7;
    @(posedge c_clk); #1;
    cmd[3] = 4'd0; din[3] = 32'd0; act[3] = 1'b0;
    repeat (4) @(posedge c_clk);
    #1;

    issue(1, 4'd1, 32'h10, 32'h20, 2'd1, 32'h30);
    @(negedge c_clk); #1;
    reset = 7'b0001000;
    #1;
    chk("async_clear", 1, out_resp[1], out_data[1], 2'd0, 32'd0);
    reset = 7'b0000000;
    @(posedge c_clk); #1;

    for (int n = 0; n < 30; n++) begin
      for (int p = 1; p <= 4; p++) begin
        c = 4'($urandom_range(0, 7));
        a = $urandom;
        b = (n % 2 == 0) ? $urandom : 32'($urandom_range(0, 40));
        if (c != 4'd0) begin
          model(c, a, b, r, d);
          launch(p, c, a, b, 1'b1, r, d);
        end else begin
          din[p] = a;
        end
      end
      step3();
    end

    repeat (5) @(posedge c_clk);
    #1;
    for (int p = 1; p <= 4; p++) begin
      total++;
      if (sbq[p-1].size() != 0) begin
        bad++;
        $display("FAIL drain port%0d pending=%0d want 0", p, sbq[p-1].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc1.md
CALC1 -- requirements
Module: calc1

Interface
REQ-001 SHALL have no parameters; all widths are fixed; bit 0 is MSB on every bus ([0:N] numbering).
REQ-002 c_clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  7 ([1:7])  asynchronous, active-high reset; the block is in reset while any bit is 1; reset[1] alone suffices.
REQ-004 reqN_cmd_in (N=1..4)  input  4 ([0:3])  per-port command.
REQ-005 reqN_data_in (N=1..4)  input  32 ([0:31])  per-port operand.
REQ-006 out_dataN (N=1..4)  output  32 ([0:31])  per-port result.
REQ-007 out_respN (N=1..4)  output  2 ([0:1])  per-port response: 0 none, 1 success, 2 error (overflow/underflow/invalid command), 3 never driven.
REQ-008 Port order SHALL be: out_data1..4, out_resp1..4, c_clk, req1_cmd_in, req1_data_in, ... req4_cmd_in, req4_data_in, reset.

Function
REQ-009 Four identical, fully independent ports; activity on one port SHALL never affect another.
REQ-010 Per-port FSM states: IDLE, OPND2, RESP.
REQ-011 IDLE: cmd=0 -> stay IDLE; cmd!=0 -> latch cmd and data as operand1, go to OPND2.
REQ-012 OPND2: latch data as operand2 unconditionally (cmd input ignored), go to RESP.
REQ-013 RESP: outputs driven for exactly one cycle; then go to IDLE and accept a new command on the following edge. A new command in the RESP cycle is ignored.
REQ-014 Latency: command at edge K, operand2 at edge K+1, out_resp/out_data valid from edge K+2 to edge K+3.
REQ-015 Outside the RESP cycle, out_respN=0 and out_dataN=0.
REQ-016 cmd 1 (add): unsigned op1+op2; carry out of bit 0 -> resp 2, data 0; else resp 1, data = sum.
REQ-017 cmd 2 (subtract): op1-op2; op2>op1 -> resp 2, data 0; else resp 1, data = difference; op1=op2 -> resp 1, data 0.
REQ-018 cmd 5 (shift left): op1 << op2[27:31], zero fill, shifted-out bits discarded, resp 1.
REQ-019 cmd 6 (shift right): op1 >> op2[27:31], logical, zero fill, resp 1; op2[0:26] ignored for shifts.
REQ-020 Any other non-zero cmd (3, 4, 7-15): still consumes the operand2 cycle; resp 2, data 0.
REQ-021 Boundaries: 0+0 -> resp 1, data 0; FFFF_FFFF+0 -> resp 1, data FFFF_FFFF; shift by 0 -> op1 unchanged.

Reset
REQ-022 While reset is asserted, all FSMs SHALL go to IDLE and all outputs and latched operands to 0, asynchronously.
REQ-023 Reset during OPND2 or RESP SHALL abort the operation; no response is produced for it.
REQ-024 The first command SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro CALC1_SHIFT_EN defined: cmds 5 and 6 behave per REQ-018/019.
REQ-026 CALC1_SHIFT_EN undefined: shift logic SHALL be absent; cmds 5 and 6 are invalid per REQ-020 (resp 2, data 0).

Verification
REQ-027 Port 1 cmd 1, op1 0000_0001, op2 01FF_FFFF -> resp 1, data 0200_0000 at edge K+2.
REQ-028 Port 1 cmd 1, op1 FFFF_FFFF, op2 0000_0001 -> resp 2, data 0; also 1FFF_FFFF+1FFF_FFFF -> resp 1, 3FFF_FFFE.
REQ-029 Port 1 cmd 2, op1 0000_0001, op2 0000_000F -> resp 2, data 0; op1 0000_000F, op2 0000_0001 -> resp 1, data 0000_000E.
REQ-030 Port 1 cmd 3 then cmd 4 (op 0000_0001) -> resp 2, data 0 each; following cycle resp 0.
REQ-031 For x=2^i (i=0..30): cmd 1, op1 x, op2 0 -> data x; cmd 5, op1 x (i<=29), op2 1 -> data 2x, resp 1 (with CALC1_SHIFT_EN).
REQ-032 Simultaneous add on ports 1-4 with different operands -> each port returns its own correct result in the same cycle; reset[1] pulse during OPND2 -> no response, outputs 0.
